// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions for the 160x120 pixel plot path.
// Holds screen geometry, address/colour widths, sink FSM states and the queued request type.
// Also provides the multiplier-free (x, y) -> linear address conversion.
package fb_pkg;

   localparam int H_RES    = 160;
   localparam int V_RES    = 120;
   localparam int FB_WORDS = H_RES * V_RES;
   localparam int ADDR_W   = 15;
   localparam int COLOUR_W = 3;

   localparam logic [7:0]        X_LIM     = 8'(H_RES);
   localparam logic [6:0]        Y_LIM     = 7'(V_RES);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      CLEAR
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]   addr;
      logic [COLOUR_W-1:0] colour;
   } req_t;

   // y*160 + x as two shifted copies of y (128y + 32y) plus x.
   function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [7:0] px, input logic [6:0] py);
      return ADDR_W'({py, 7'b0}) + ADDR_W'({py, 5'b0}) + ADDR_W'(px);
   endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous request FIFO, DEPTH entries of req_t.
// Latency: pushed entry visible at the head the cycle after the push.
// Backpressure: full_o/empty_o are registered-state derived; caller must not push when full or pop when empty.
// Ports: push_i/push_dat_i write side, pop_i/pop_dat_o read side (head is shown combinationally), full_o, empty_o.
module pixel_fifo
   import fb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push_i,
   input  req_t push_dat_i,
   input  logic pop_i,
   output req_t pop_dat_o,
   output logic full_o,
   output logic empty_o
);

   localparam int AW = $clog2(DEPTH);

   req_t        mem_q [DEPTH];
   logic [AW:0] wr_q;
   logic [AW:0] rd_q;

   // Pointers carry one extra wrap bit to tell full from empty.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + (AW+1)'(1);
         if (pop_i)  rd_q <= rd_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q[AW-1:0]] <= push_dat_i;
   end

   assign pop_dat_o = mem_q[rd_q[AW-1:0]];
   assign empty_o   = (wr_q == rd_q);
   assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/pixel_plot_sink.sv
// Plot-request sink: clips, converts (x, y) to a linear address, buffers, and writes the frame buffer; also runs a whole-screen clear.
// Latency: request accepted at edge N into an empty FIFO drives mem_we after edge N+1; 1 write/cycle sustained.
// Backpressure: plot_ready drops when the FIFO is full or a clear is pending/active; mem_addr/mem_data hold while mem_we && !mem_ready.
// Ports: x/y/colour/plot/plot_ready/clip request side; clear/clear_colour clear control; busy status; mem_* frame-buffer write port.
module pixel_plot_sink
   import fb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          x,
   input  logic [6:0]          y,
   input  logic [COLOUR_W-1:0] colour,
   input  logic                plot,
   output logic                plot_ready,
   output logic                clip,
   input  logic                clear,
   input  logic [COLOUR_W-1:0] clear_colour,
   output logic                busy,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [COLOUR_W-1:0] mem_data,
   output logic                mem_we,
   input  logic                mem_ready
);

   state_t              state_q, state_d;
   logic                init_q;
   logic                clip_q, clip_d;
   logic                clr_pend_q, clr_pend_d;
   logic [COLOUR_W-1:0] fill_q, fill_d;
   req_t                out_q, out_d;
   logic                out_vld_q, out_vld_d;

   logic fifo_full, fifo_empty;
   req_t fifo_head, new_req;
   logic accept, in_range, push, pop, complete, clear_go, last_addr;

   assign accept    = plot && plot_ready;
   assign in_range  = (x < X_LIM) && (y < Y_LIM);
   assign push      = accept && in_range;
   assign complete  = out_vld_q && mem_ready;
   // The clear sweep owns the output register, so the FIFO is never read during CLEAR.
   assign pop       = !fifo_empty && (state_q != CLEAR) && (!out_vld_q || mem_ready);
   assign clear_go  = (state_q == IDLE) && clr_pend_q && fifo_empty && !out_vld_q;
   assign last_addr = (out_q.addr == LAST_ADDR);
   assign new_req   = '{addr: xy_to_addr(x, y), colour: colour};

   pixel_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (push),
      .push_dat_i (new_req),
      .pop_i      (pop),
      .pop_dat_o  (fifo_head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   // FSM: state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (push) state_d = DRAIN;
                else if (clear_go) state_d = CLEAR;
         DRAIN: if (fifo_empty && !push && (!out_vld_q || complete)) state_d = IDLE;
         CLEAR: if (complete && last_addr) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM: outputs. init_q keeps plot_ready low until the first edge after reset.
   always_comb begin
      plot_ready = init_q && !fifo_full && (state_q != CLEAR) && !clr_pend_q;
      busy       = !fifo_empty || out_vld_q || clr_pend_q || (state_q == CLEAR);
   end

   // Datapath next state: clip pulse, clear request latch, output register / sweep counter.
   always_comb begin
      clip_d     = accept && !in_range;
      clr_pend_d = clr_pend_q;
      fill_d     = fill_q;
      out_d      = out_q;
      out_vld_d  = out_vld_q;

      if (clear_go) begin
         clr_pend_d = 1'b0;
      end else if (clear && !clr_pend_q && (state_q != CLEAR)) begin
         clr_pend_d = 1'b1;
         fill_d     = clear_colour;
      end

      if (clear_go) begin
         out_vld_d = 1'b1;
         out_d     = '{addr: '0, colour: fill_q};
      end else if (state_q == CLEAR) begin
         // The output register address doubles as the sweep counter.
         if (complete) begin
            if (last_addr) out_vld_d  = 1'b0;
            else           out_d.addr = out_q.addr + ADDR_W'(1);
         end
      end else if (pop) begin
         out_vld_d = 1'b1;
         out_d     = fifo_head;
      end else if (complete) begin
         out_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         init_q     <= 1'b0;
         clip_q     <= 1'b0;
         clr_pend_q <= 1'b0;
         fill_q     <= '0;
         out_q      <= '0;
         out_vld_q  <= 1'b0;
      end else begin
         init_q     <= 1'b1;
         clip_q     <= clip_d;
         clr_pend_q <= clr_pend_d;
         fill_q     <= fill_d;
         out_q      <= out_d;
         out_vld_q  <= out_vld_d;
      end
   end

   assign clip     = clip_q;
   assign mem_we   = out_vld_q;
   assign mem_addr = out_q.addr;
   assign mem_data = out_q.colour;

endmodule

// File: tb/tb_pixel_plot_sink.sv
module tb_pixel_plot_sink;
   import fb_pkg::*;

   logic                clk = 1'b0;
   logic                reset;
   logic [7:0]          x;
   logic [6:0]          y;
   logic [COLOUR_W-1:0] colour;
   logic                plot;
   logic                plot_ready;
   logic                clip;
   logic                clear;
   logic [COLOUR_W-1:0] clear_colour;
   logic                busy;
   logic [ADDR_W-1:0]   mem_addr;
   logic [COLOUR_W-1:0] mem_data;
   logic                mem_we;
   logic                mem_ready;

   always #10 clk = ~clk;

   pixel_plot_sink #(.FIFO_DEPTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .x            (x),
      .y            (y),
      .colour       (colour),
      .plot         (plot),
      .plot_ready   (plot_ready),
      .clip         (clip),
      .clear        (clear),
      .clear_colour (clear_colour),
      .busy         (busy),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .mem_we       (mem_we),
      .mem_ready    (mem_ready)
   );

   typedef struct {
      int addr;
      int data;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   wr_count = 0;
   bit   chk_clear = 1'b0;
   bit   rnd_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("FAIL %s: timed out", name);
   endtask

   // Scoreboard monitor: compares each completed write against the expected queue,
   // checks that a stalled write holds its address/data, and watches the clear window.
   initial begin
      bit                  stall;
      logic [ADDR_W-1:0]   h_addr;
      logic [COLOUR_W-1:0] h_data;
      exp_t                e;
      stall = 1'b0;
      h_addr = '0;
      h_data = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               check("stall_we", mem_we, 1);
               check("stall_addr", mem_addr, h_addr);
               check("stall_data", mem_data, h_data);
            end
            if (mem_we && mem_ready) begin
               wr_count++;
               if (q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_write: addr %0d data %0d, no write expected", mem_addr, mem_data);
               end else begin
                  e = q.pop_front();
                  check("wr_addr", mem_addr, e.addr);
                  check("wr_data", mem_data, e.data);
               end
            end
            stall  = mem_we && !mem_ready;
            h_addr = mem_addr;
            h_data = mem_data;
            if (chk_clear) begin
               check("clr_plot_ready", plot_ready, 0);
               check("clr_busy", busy, 1);
            end
         end
      end
   end

   // Random write acceptance when enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_en) mem_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic do_plot(input int px, input int py, input int pc);
      int   n;
      exp_t e;
      n = 0;
      while (!plot_ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!plot_ready) timeout("plot_ready_wait");
      x      = px[7:0];
      y      = py[6:0];
      colour = pc[COLOUR_W-1:0];
      plot   = 1'b1;
      @(posedge clk);
      #1;
      plot = 1'b0;
      if (px < H_RES && py < V_RES) begin
         e.addr = py * H_RES + px;
         e.data = pc;
         q.push_back(e);
      end
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while ((busy || q.size() != 0) && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (busy || q.size() != 0) timeout(name);
   endtask

   task automatic push_clear(input int c);
      exp_t e;
      for (int a = 0; a < FB_WORDS; a++) begin
         e.addr = a;
         e.data = c;
         q.push_back(e);
      end
   endtask

   initial begin
      int   acc;
      int   base;
      int   n;
      logic pr;
      exp_t e;

      reset = 1'b0; plot = 1'b0; clear = 1'b0; x = '0; y = '0; colour = '0;
      clear_colour = '0; mem_ready = 1'b1;

      // Reset state
      #5;
      check("rst_mem_we", mem_we, 0);
      check("rst_busy", busy, 0);
      check("rst_clip", clip, 0);
      check("rst_plot_ready", plot_ready, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_data", mem_data, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      check("rel_plot_ready_0", plot_ready, 0);
      @(posedge clk);
      #1;
      check("rel_plot_ready_1", plot_ready, 1);

      // Single plot: (10,5) -> 810, colour 5; write visible after the edge following acceptance
      base = wr_count;
      do_plot(10, 5, 5);
      check("single_we_n", mem_we, 0);
      @(posedge clk);
      #1;
      check("single_we_n1", mem_we, 1);
      check("single_addr", mem_addr, 810);
      @(posedge clk);
      #1;
      check("single_we_n2", mem_we, 0);
      wait_idle("single_idle");
      check("single_count", wr_count - base, 1);

      // Clipping
      base = wr_count;
      check("clip_ready_a", plot_ready, 1);
      do_plot(160, 0, 1);
      check("clip_pulse_a", clip, 1);
      @(posedge clk); #1;
      check("clip_fall_a", clip, 0);
      check("clip_ready_b", plot_ready, 1);
      do_plot(0, 120, 2);
      check("clip_pulse_b", clip, 1);
      @(posedge clk); #1;
      check("clip_fall_b", clip, 0);
      check("clip_ready_c", plot_ready, 1);
      do_plot(255, 127, 3);
      check("clip_pulse_c", clip, 1);
      @(posedge clk); #1;
      check("clip_fall_c", clip, 0);
      check("clip_ready_end", plot_ready, 1);
      repeat (3) @(posedge clk);
      #1;
      check("clip_no_write", wr_count - base, 0);
      check("clip_busy", busy, 0);

      // Backpressure: 4 in FIFO + 1 in the output register
      base = wr_count;
      mem_ready = 1'b0;
      acc = 0;
      plot = 1'b1;
      for (int i = 0; i < 8; i++) begin
         x = 8'(acc); y = 7'(acc + 1); colour = 3'(acc);
         pr = plot_ready;
         @(posedge clk);
         #1;
         if (pr) begin
            e.addr = (acc + 1) * H_RES + acc;
            e.data = acc;
            q.push_back(e);
            acc++;
         end
      end
      plot = 1'b0;
      check("bp_accepts", acc, 5);
      check("bp_ready_low", plot_ready, 0);
      check("bp_no_write", wr_count - base, 0);
      mem_ready = 1'b1;
      wait_idle("bp_idle");
      check("bp_count", wr_count - base, 5);
      check("bp_ready_back", plot_ready, 1);

      // Reset during DRAIN
      mem_ready = 1'b0;
      do_plot(3, 3, 1);
      @(posedge clk);
      #1;
      check("drain_we_pre", mem_we, 1);
      reset = 1'b0;
      #1;
      check("mid_rst_we", mem_we, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_clip", clip, 0);
      q.delete();
      @(posedge clk);
      #1;
      reset = 1'b1;
      mem_ready = 1'b1;
      check("mid_rel_ready_0", plot_ready, 0);
      @(posedge clk);
      #1;
      check("mid_rel_ready_1", plot_ready, 1);
      check("mid_rel_busy", busy, 0);

      // Clear behind two queued plots, random write acceptance
      mem_ready = 1'b0;
      do_plot(1, 1, 6);
      do_plot(2, 2, 7);
      clear_colour = 3'b010;
      clear = 1'b1;
      push_clear(2);
      @(posedge clk);
      #1;
      clear = 1'b0;
      check("pend_ready", plot_ready, 0);
      check("pend_busy", busy, 1);
      chk_clear = 1'b1;
      rnd_en = 1'b1;
      n = 0;
      while (q.size() != 0 && n < 60000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk_clear = 1'b0;
      rnd_en = 1'b0;
      mem_ready = 1'b1;
      if (q.size() != 0) timeout("clear_sweep");
      check("clear_busy_fall", busy, 0);
      check("clear_ready_back", plot_ready, 1);
      check("clear_we_off", mem_we, 0);

      // Reset mid-clear, then a normal plot
      clear_colour = 3'b100;
      clear = 1'b1;
      push_clear(4);
      @(posedge clk);
      #1;
      clear = 1'b0;
      n = 0;
      while (!(mem_we && mem_addr >= 15'd5000) && n < 10000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!(mem_we && mem_addr >= 15'd5000)) timeout("clear_reach_5000");
      reset = 1'b0;
      #1;
      check("clr_rst_we", mem_we, 0);
      check("clr_rst_busy", busy, 0);
      q.delete();
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("clr_rel_ready", plot_ready, 1);
      base = wr_count;
      do_plot(0, 0, 7);
      wait_idle("post_clear_idle");
      repeat (20) @(posedge clk);
      #1;
      check("post_clear_count", wr_count - base, 1);
      check("post_clear_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
